// File: rtl/array_18_port_ctrl_if.sv
// rtl/array_18_port_ctrl_if.sv - client request/response channel and RW0 macro port bundles
interface array_18_port_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int LANES  = 10,
    parameter int LANE_W = 18
);
    localparam int DATA_W = LANES * LANE_W;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LANES-1:0]  req_mask;
    logic [DATA_W-1:0] req_data;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;

    modport master (
        output req_valid, req_write, req_addr, req_mask, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_mask, req_data, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

interface array_18_rw_if #(
    parameter int ADDR_W = 10,
    parameter int LANES  = 10,
    parameter int LANE_W = 18
);
    localparam int DATA_W = LANES * LANE_W;

    logic [ADDR_W-1:0] RW0_addr;
    logic              RW0_en;
    logic              RW0_wmode;
    logic [LANES-1:0]  RW0_wmask;
    logic [DATA_W-1:0] RW0_wdata;
    logic [DATA_W-1:0] RW0_rdata;

    modport master (
        output RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
        input  RW0_rdata
    );
    modport slave (
        input  RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
        output RW0_rdata
    );
endinterface

// File: rtl/array_18_port_ctrl.sv
// rtl/array_18_port_ctrl.sv - zero-filling request controller for a 1024x180 RW0 array macro
module array_18_port_ctrl #(
    parameter int ADDR_W = 10,
    parameter int LANES  = 10,
    parameter int LANE_W = 18
) (
    input  logic                clock,
    input  logic                reset_n,
    array_18_port_ctrl_if.slave req_if,
    array_18_rw_if.master       rw_if,
    output logic                init_done
);
    localparam int DATA_W = LANES * LANE_W;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        occ_q, occ_d;
    logic [1:0]        rd_ptr_q, rd_ptr_d;
    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] fifo_q [3];

    logic [2:0]        credit;
    logic              run;
    logic              accept;
    logic              en_raw;
    logic              push;
    logic              pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {ADDR_W{1'b1}}) begin
                state_d = ST_RUN;
            end
        end
    end

    // A pending read occupies a credit so the queue can always absorb the returning word.
    always_comb begin
        run              = (state_q == ST_RUN);
        credit           = {1'b0, occ_q} + {2'b00, inflight_q};
        req_if.req_ready = run && (credit < 3'd3);
        accept           = req_if.req_valid && req_if.req_ready;
        init_done        = run;
        if (run) begin
            rw_if.RW0_addr  = req_if.req_addr;
            en_raw          = accept;
            rw_if.RW0_wmode = req_if.req_write;
            rw_if.RW0_wmask = req_if.req_mask;
            rw_if.RW0_wdata = req_if.req_data;
        end else begin
            rw_if.RW0_addr  = cnt_q;
            en_raw          = 1'b1;
            rw_if.RW0_wmode = 1'b1;
            rw_if.RW0_wmask = {LANES{1'b1}};
            rw_if.RW0_wdata = '0;
        end
        // Macro enable must drop the instant reset asserts, even mid-sweep.
        rw_if.RW0_en = reset_n && en_raw;
    end

    always_comb begin
        push       = inflight_q;
        pop        = (occ_q != 2'd0) && req_if.resp_ready;
        inflight_d = accept && !req_if.req_write;
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            rd_ptr_q   <= 2'd0;
            wr_ptr_q   <= 2'd0;
        end else begin
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Read data lands one edge after the macro read; capture it straight into the queue.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= rw_if.RW0_rdata;
        end
    end

    assign req_if.resp_valid = (occ_q != 2'd0);
    assign req_if.resp_data  = fifo_q[rd_ptr_q];

endmodule
